// File: rtl/gfx_pkg.sv
// Shared constants, strip bundle and column-order helper
// for the graphics plane shifter.
package gfx_pkg;

  localparam int GFX_PLANES = 6;
  localparam int GFX_PIX    = 8;
  localparam int GFX_PAL_W  = 2;

  typedef struct packed {
    logic [GFX_PLANES*GFX_PIX-1:0] data;
    logic                          flip;
    logic [GFX_PAL_W-1:0]          pal;
  } strip_t;

  // cnt counts down from pix; flip walks columns upward
  function automatic int col_sel(
    logic flip,
    int   cnt,
    int   pix = GFX_PIX
  );
    return flip ? (pix - cnt) : (cnt - 1);
  endfunction

endpackage

// File: rtl/gfx_plane_shifter_if.sv
// Load handshake and pixel output bundle for all
// shifter channels.
interface gfx_plane_shifter_if #(
  parameter int PLANES   = 6,
  parameter int PIX      = 8,
  parameter int CHANNELS = 2,
  parameter int PAL_W    = 2
);

  logic                                  pix_en;
  logic [CHANNELS-1:0]                   ld_valid;
  logic [CHANNELS-1:0]                   ld_ready;
  logic [CHANNELS-1:0][PLANES*PIX-1:0]   ld_data;
  logic [CHANNELS-1:0]                   ld_flip;
  logic [CHANNELS-1:0][PAL_W-1:0]        ld_pal;
  logic [CHANNELS-1:0][PLANES-1:0]       ld_norom;
  logic [CHANNELS-1:0][PLANES-1:0]       ld_fill;
  logic [CHANNELS-1:0][PLANES-1:0]       pix_out;
  logic [CHANNELS-1:0][PAL_W-1:0]        pal_out;
  logic [CHANNELS-1:0]                   pix_valid;
  logic [CHANNELS-1:0]                   underrun;
  logic [CHANNELS-1:0]                   underrun_clr;

  modport master (
    output pix_en, ld_valid, ld_data, ld_flip,
    output ld_pal, ld_norom, ld_fill, underrun_clr,
    input  ld_ready, pix_out, pal_out,
    input  pix_valid, underrun
  );

  modport slave (
    input  pix_en, ld_valid, ld_data, ld_flip,
    input  ld_pal, ld_norom, ld_fill, underrun_clr,
    output ld_ready, pix_out, pal_out,
    output pix_valid, underrun
  );

endinterface

// File: rtl/gfx_shift_chan.sv
// One shifter channel: staging buffer, column shifter,
// pixel counter and sticky underrun.
module gfx_shift_chan
  import gfx_pkg::*;
#(
  parameter int PLANES = GFX_PLANES,
  parameter int PIX    = GFX_PIX,
  parameter int PAL_W  = GFX_PAL_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_en,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [PLANES*PIX-1:0] ld_data,
  input  logic                  ld_flip,
  input  logic [PAL_W-1:0]      ld_pal,
  input  logic [PLANES-1:0]     ld_norom,
  input  logic [PLANES-1:0]     ld_fill,
  output logic [PLANES-1:0]     pix_out,
  output logic [PAL_W-1:0]      pal_out,
  output logic                  pix_valid,
  output logic                  underrun,
  input  logic                  underrun_clr
);

  localparam int CW  = $clog2(PIX + 1);
  localparam int CIW = (PIX > 1) ? $clog2(PIX) : 1;

  typedef struct packed {
    logic [PLANES*PIX-1:0] data;
    logic                  flip;
    logic [PAL_W-1:0]      pal;
  } chan_strip_t;

  chan_strip_t stg, sh, ld_word;
  logic        stg_full, armed;
  logic [CW-1:0] cnt;
  logic        accept, xfer, avail;
  logic [CIW-1:0] col;
  logic [PLANES-1:0] col_pix;

  logic [PLANES-1:0][PIX-1:0] ld_d2, ld_sub, sh_d2;

  assign ld_d2 = ld_data;
  assign sh_d2 = sh.data;

  for (genvar p = 0; p < PLANES; p++) begin : g_pl
    assign ld_sub[p]  = ld_norom[p] ? {PIX{ld_fill[p]}}
                                    : ld_d2[p];
    assign col_pix[p] = sh_d2[p][col];
  end

  always_comb begin
    ld_word      = '0;
    ld_word.data = ld_sub;
    ld_word.flip = ld_flip;
    ld_word.pal  = ld_pal;
  end

  assign col      = CIW'(col_sel(sh.flip, int'(cnt), PIX));
  assign ld_ready = ~stg_full;
  assign accept   = ld_valid & ~stg_full;
  assign avail    = (cnt != '0);
  // cnt==1 with pix_en hands over right after the last pixel
  assign xfer     = stg_full &
                    (~avail | (pix_en & (cnt == CW'(1))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg       <= '0;
      sh        <= '0;
      stg_full  <= 1'b0;
      cnt       <= '0;
      armed     <= 1'b0;
      pix_out   <= '0;
      pal_out   <= '0;
      pix_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (accept) begin
        stg      <= ld_word;
        stg_full <= 1'b1;
      end else if (xfer) begin
        stg_full <= 1'b0;
      end
      if (xfer) begin
        sh    <= stg;
        cnt   <= CW'(PIX);
        armed <= 1'b1;
      end else if (pix_en && avail) begin
        cnt <= cnt - CW'(1);
      end
      if (pix_en) begin
        if (avail) begin
          pix_out   <= col_pix;
          pal_out   <= sh.pal;
          pix_valid <= 1'b1;
        end else begin
          pix_out   <= '0;
          pal_out   <= '0;
          pix_valid <= 1'b0;
        end
      end
      if (pix_en && !avail && armed)
        underrun <= 1'b1;
      else if (underrun_clr)
        underrun <= 1'b0;
    end
  end

endmodule

// File: rtl/gfx_plane_shifter.sv
// Multi-channel graphics pixel serialiser; one
// independent shifter channel per generate slot.
module gfx_plane_shifter
  import gfx_pkg::*;
#(
  parameter int PLANES   = GFX_PLANES,
  parameter int PIX      = GFX_PIX,
  parameter int CHANNELS = 2,
  parameter int PAL_W    = GFX_PAL_W
) (
  input logic sysclk,
  input logic reset_b,
  gfx_plane_shifter_if.slave bus
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    gfx_shift_chan #(
      .PLANES (PLANES),
      .PIX    (PIX),
      .PAL_W  (PAL_W)
    ) u_chan (
      .clk          (sysclk),
      .rst_n        (reset_b),
      .pix_en       (bus.pix_en),
      .ld_valid     (bus.ld_valid[c]),
      .ld_ready     (bus.ld_ready[c]),
      .ld_data      (bus.ld_data[c]),
      .ld_flip      (bus.ld_flip[c]),
      .ld_pal       (bus.ld_pal[c]),
      .ld_norom     (bus.ld_norom[c]),
      .ld_fill      (bus.ld_fill[c]),
      .pix_out      (bus.pix_out[c]),
      .pal_out      (bus.pal_out[c]),
      .pix_valid    (bus.pix_valid[c]),
      .underrun     (bus.underrun[c]),
      .underrun_clr (bus.underrun_clr[c])
    );
  end

endmodule

// File: doc/gfx_plane_shifter.md
Name: gfx_plane_shifter

Overview:
- Parametrised multi-channel graphics pixel serialiser. Successor to the fixed 6-plane playfield/motion-object shifter bank in the cartridge graphics path.
- Each channel takes a parallel load of PLANES×PIX ROM bits plus palette, flip and per-plane no-ROM substitution. It emits one PLANES-bit pixel per pixel-enable, in forward or reversed column order.
- Adds features the fixed design lacks:
  - a one-deep staging buffer with a ready/valid load handshake, giving gapless back-to-back strips;
  - an explicit pixel-valid output;
  - sticky underrun detection.

Parameters:
- PLANES, 6: bit planes per pixel.
- PIX, 8: pixels per load, i.e. columns per plane.
- CHANNELS, 2: independent shifter channels (ch0 = playfield, ch1 = motion object by convention).
- PAL_W, 2: palette bits carried alongside each pixel.

Ports:
- sysclk  in  1  system clock; all state is updated on its rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- pix_en  in  1  pixel-rate enable, shared by all channels.
- ld_valid  in  CHANNELS  per-channel load request.
- ld_ready  out  CHANNELS  per-channel staging buffer empty; registered.
- ld_data  in  CHANNELS×PLANES×PIX  strip data; bit [c][p*PIX+i] = channel c, plane p, column i.
- ld_flip  in  CHANNELS  1 = emit column 0 first; 0 = emit column PIX-1 first.
- ld_pal  in  CHANNELS×PAL_W  palette bits for the strip.
- ld_norom  in  CHANNELS×PLANES  1 = replace plane p with its fill bit.
- ld_fill  in  CHANNELS×PLANES  fill value replicated across all PIX columns of a substituted plane.
- pix_out  out  CHANNELS×PLANES  current pixel, registered.
- pal_out  out  CHANNELS×PAL_W  palette of the current pixel, registered.
- pix_valid  out  CHANNELS  pix_out/pal_out carry strip data.
- underrun  out  CHANNELS  sticky: a pix_en occurred with no pixel available after the first load.
- underrun_clr  in  CHANNELS  clears the corresponding underrun bit.

Behaviour:
- Reset (async, reset_b=0) applies immediately, even mid-strip. All outputs go to 0 except ld_ready, which goes to all-ones. All state clears: shifters, staging buffers, counts, armed flags.
- Per-channel state:
  - staging buffer: stg_full, data, flip, pal;
  - shifter: PLANES×PIX bits, cnt in 0..PIX, flip, pal;
  - armed flag.
- Load accept: ld_valid & ld_ready at an edge.
  - ld_norom substitution happens at accept time.
  - The word is captured into staging and stg_full is set.
  - ld_ready = ~stg_full, registered. No accept is possible in the cycle staging drains.
- Transfer staging → shifter occurs when stg_full and either:
  - (a) cnt==0, independent of pix_en; or
  - (b) pix_en & cnt==1, so the new strip follows the last pixel with no gap.
  - On transfer: cnt←PIX, stg_full←0, armed←1.
- Pixel emit on pix_en:
  - If cnt>0: pix_out←column selected by flip and PIX-cnt; pal_out←shifter pal; pix_valid←1; cnt←cnt-1.
  - Column order: flip=0 emits PIX-1 first, down to 0; flip=1 emits 0 first, up to PIX-1.
  - If cnt==0 (no pixel available): pix_out←0, pal_out←0, pix_valid←0; underrun←1 if armed.
- pix_en=0: outputs, cnt and shifter hold. Load and transfer rule (a) still operate.
- Latency: accept at edge T → transfer at T+1 → first pixel registered at the first pix_en edge ≥ T+2.
- underrun_clr and a new underrun event in the same cycle: set wins.
- Channels are fully independent and share only sysclk, reset_b and pix_en.

Decomposition:
- Shared package gfx_pkg holds:
  - default constants (GFX_PLANES=6, GFX_PIX=8, GFX_PAL_W=2);
  - typedef strip_t: packed struct {data, flip, pal};
  - the pixel-index function col_sel(flip, cnt).
- One sub-module, gfx_shift_chan: a single channel holding staging, shifter and counters. Top level instantiates it CHANNELS times with a generate loop.

Test Plan:
- Forward order: ch0 plane0=8'hC1, others 0, flip=0, ld_pal=2'b10, pix_en=1 → plane0 emits 1,1,0,0,0,0,0,1 over 8 consecutive edges. pal_out=2'b10 and pix_valid=1 throughout; first output at T+2.
- Flip: same strip, flip=1 → plane0 emits 1,0,0,0,0,0,1,1.
- Back-to-back: first strip all planes 8'hFF, second 8'h00, second load presented while the first shifts → 16 contiguous pix_valid=1 cycles (8 all-ones then 8 zeros). ld_ready=0 while staging is held; underrun stays 0.
- No-ROM: ld_norom[5]=1, ld_fill[5]=1, ld_data plane5=8'h00 → pix_out[5]=1 for all 8 pixels; other planes follow data.
- Gated pixel clock: pix_en toggling 1,0,1,0 → output changes only on pix_en=1 edges. 8 pixels take 16 cycles; cnt holds on pix_en=0.
- Underrun and reset:
  - Single load, pix_en kept high → after the 8th pixel, pix_valid=0 and pix_out=0, and underrun=1 until underrun_clr.
  - Separately, assert reset_b=0 mid-strip → pix_out, pix_valid and underrun go to 0 immediately and ld_ready goes to all-ones.
